// File: rtl/seg_scan_mux.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// seg_scan_mux
// Time-multiplexed scan driver for a 4-digit common-anode seven-segment
// display. A 16-bit hex value is captured into a pending register and copied
// into the displayed (shadow) copy only at frame boundaries, so a scan never
// shows a mix of old and new digits. Each digit slot lasts REFRESH_DIV cycles.
// The first DEAD cycles of every slot are blanked to prevent ghosting.
//
// Parameters
//   REFRESH_DIV  cycles per digit slot (4 .. 2^20)
//   DEAD         blanking cycles at the start of each slot (1 .. REFRESH_DIV-1)
//
// Ports
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous active-high reset
//   load    in   1   capture strobe for value
//   value   in  16   hex value to display, digit 0 = value[3:0]
//   lz_en   in   1   suppress leading zeros (live, not registered)
//   nibble  out  4   hex digit of the current slot, for the decoder
//   an      out  4   digit enables, active low, an[k] drives digit k
//   frame   out  1   one-cycle pulse on the first cycle of a new frame
// -----------------------------------------------------------------------------
module seg_scan_mux #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_en,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  logic [15:0]   r_pending;
  logic [15:0]   r_shadow;
  logic          r_frame;

  logic          w_slot_end;
  logic          w_frame_edge;
  logic          w_dead;
  logic [3:0]    w_sup;

  assign w_slot_end   = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_frame_edge = w_slot_end && (r_dig == 2'd3);
  assign w_dead       = (r_cnt < CW'(DEAD));

  // NOTE: the value and shadow registers are reset too, because the
  // display must come out of reset showing a defined 0, not power-up garbage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_dig     <= '0;
      r_pending <= '0;
      r_shadow  <= '0;
      r_frame   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge state; the shadow copy below relies on reading the old
      // pending value.
      if (w_slot_end) begin
        r_cnt <= '0;
        r_dig <= r_dig + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (load) r_pending <= value;

      // A load on the boundary edge itself bypasses pending so it is shown
      // in the very next frame.
      if (w_frame_edge) r_shadow <= load ? value : r_pending;

      r_frame <= w_frame_edge;
    end
  end

  // Digit k is blank under leading-zero suppression when it and every more
  // significant nibble are zero. Digit 0 always shows, so 0 renders as "0".
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_sup    = 4'b0000;
    w_sup[1] = lz_en && (r_shadow[15:4]  == 12'h000);
    w_sup[2] = lz_en && (r_shadow[15:8]  == 8'h00);
    w_sup[3] = lz_en && (r_shadow[15:12] == 4'h0);
  end

  always_comb begin
    an = 4'b1111;
    if (!w_dead && !w_sup[r_dig]) an = ~(4'b0001 << r_dig);
  end

  assign nibble = r_shadow[{r_dig, 2'b00} +: 4];
  assign frame  = r_frame;

endmodule

// File: tb/tb_seg_scan_mux.sv
`timescale 1ns / 1ps
module tb_seg_scan_mux;

  localparam int RD    = 8;
  localparam int DT    = 2;
  localparam int FRAME = 4 * RD;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic        lz_en;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        frame;

  always #5 clk = ~clk;

  seg_scan_mux #(.REFRESH_DIV(RD), .DEAD(DT)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .value  (value),
    .lz_en  (lz_en),
    .nibble (nibble),
    .an     (an),
    .frame  (frame)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: elapsed edges since reset plus the two value registers.
  int unsigned m_t;
  logic [15:0] m_pend;
  logic [15:0] m_shad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  function automatic logic [3:0] exp_an();
    int d;
    int pos;
    logic [15:0] upper;
    d     = (m_t / RD) % 4;
    pos   = m_t % RD;
    upper = m_shad >> (4 * d);
    if (pos < DT) return 4'hF;
    if (lz_en && d >= 1 && upper == 16'h0) return 4'hF;
    return ~(4'b0001 << d);
  endfunction

  function automatic logic [3:0] exp_nib();
    int d;
    logic [15:0] sh;
    d  = (m_t / RD) % 4;
    sh = m_shad >> (4 * d);
    return sh[3:0];
  endfunction

  function automatic logic exp_frame();
    return (m_t != 0) && (m_t % FRAME == 0);
  endfunction

  task automatic model_edge();
    if (m_t % FRAME == FRAME - 1) m_shad = load ? value : m_pend;
    if (load) m_pend = value;
    m_t++;
  endtask

  task automatic check_model();
    check("model_an", 32'(an), 32'(exp_an()));
    check("model_nibble", 32'(nibble), 32'(exp_nib()));
    check("model_frame", 32'(frame), 32'(exp_frame()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame !== 1'b1 && n < 2 * FRAME);
    check("wait_frame", 32'(frame), 32'd1);
  endtask

  // Advance until the cycle at position pos within the frame (model time).
  task automatic goto_pos(input int pos);
    int n = 0;
    while ((m_t % FRAME) != pos && n < 2 * FRAME) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [15:0] value;
    logic        lz;
    int          dig;
    logic [3:0]  an;
    logic [3:0]  nib;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{16'h12AF, 1'b0, 0, 4'b1110, 4'hF};
    vecs[1]  = '{16'h12AF, 1'b0, 1, 4'b1101, 4'hA};
    vecs[2]  = '{16'h12AF, 1'b0, 2, 4'b1011, 4'h2};
    vecs[3]  = '{16'h12AF, 1'b0, 3, 4'b0111, 4'h1};
    vecs[4]  = '{16'h0050, 1'b1, 0, 4'b1110, 4'h0};
    vecs[5]  = '{16'h0050, 1'b1, 1, 4'b1101, 4'h5};
    vecs[6]  = '{16'h0050, 1'b1, 2, 4'b1111, 4'h0};
    vecs[7]  = '{16'h0050, 1'b1, 3, 4'b1111, 4'h0};
    vecs[8]  = '{16'h0000, 1'b1, 0, 4'b1110, 4'h0};
    vecs[9]  = '{16'h0000, 1'b1, 1, 4'b1111, 4'h0};
    vecs[10] = '{16'h0000, 1'b1, 2, 4'b1111, 4'h0};
    vecs[11] = '{16'h0000, 1'b1, 3, 4'b1111, 4'h0};

    reset = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    lz_en = 1'b0;
    #12;
    check("reset_an", 32'(an), 32'hF);
    check("reset_nibble", 32'(nibble), 32'h0);
    check("reset_frame", 32'(frame), 32'h0);
    reset  = 1'b0;
    m_t    = 0;
    m_pend = 16'h0;
    m_shad = 16'h0;
    check_model();

    // First slot after release: blank for DEAD cycles, then digit 0 enabled.
    for (int i = 1; i < RD; i++) begin
      tick();
      check("first_slot_an", 32'(an), (i >= DT) ? 32'hE : 32'hF);
    end

    // Frame period.
    begin
      int n;
      wait_frame();
      n = 0;
      do begin
        tick();
        n++;
      end while (frame !== 1'b1 && n < 2 * FRAME);
      check("frame_period", n, FRAME);
    end

    // Table-driven scan and leading-zero vectors.
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || vecs[i].value != vecs[i-1].value || vecs[i].lz != vecs[i-1].lz) begin
        lz_en = vecs[i].lz;
        pulse_load(vecs[i].value);
        wait_frame();
      end
      goto_pos(vecs[i].dig * RD + 4);
      check($sformatf("vec%0d_an", i), 32'(an), 32'(vecs[i].an));
      check($sformatf("vec%0d_nib", i), 32'(nibble), 32'(vecs[i].nib));
    end

    // Live lz_en: with 0000 shown in digit 3's slot, clearing lz_en enables it at once.
    goto_pos(3 * RD + 4);
    check("lz_live_on", 32'(an), 32'hF);
    lz_en = 1'b0;
    #1;
    check("lz_live_off", 32'(an), 32'h7);
    lz_en = 1'b1;
    #1;
    check("lz_live_back", 32'(an), 32'hF);
    lz_en = 1'b0;

    // No tearing: a load during digit 1's slot does not disturb digits 2 and 3.
    pulse_load(16'h12AF);
    wait_frame();
    goto_pos(RD + 3);
    pulse_load(16'h3456);
    goto_pos(2 * RD + 4);
    check("tear_d2", 32'(nibble), 32'h2);
    goto_pos(3 * RD + 4);
    check("tear_d3", 32'(nibble), 32'h1);
    wait_frame();
    check("tear_new_d0_blank", 32'(an), 32'hF);
    check("tear_new_d0", 32'(nibble), 32'h6);
    goto_pos(RD + 4);
    check("tear_new_d1", 32'(nibble), 32'h5);

    // Load exactly on the frame edge bypasses pending.
    goto_pos(5);
    pulse_load(16'h1111);
    goto_pos(FRAME - 1);
    pulse_load(16'hBEEF);
    check("bnd_frame", 32'(frame), 32'h1);
    check("bnd_nib", 32'(nibble), 32'hF);
    goto_pos(4);
    check("bnd_an", 32'(an), 32'hE);
    goto_pos(RD + 4);
    check("bnd_d1", 32'(nibble), 32'hE);
    // Pending now holds BEEF; a boundary load of 0001 must still win.
    goto_pos(FRAME - 1);
    pulse_load(16'h0001);
    check("bnd2_nib", 32'(nibble), 32'h1);
    goto_pos(RD + 4);
    check("bnd2_d1", 32'(nibble), 32'h0);

    // Asynchronous reset mid-slot, with digit 0 enabled and nonzero.
    goto_pos(4);
    check("prerst_an", 32'(an), 32'hE);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_nibble", 32'(nibble), 32'h0);
    check("midrst_frame", 32'(frame), 32'h0);
    #2;
    reset  = 1'b0;
    m_t    = 0;
    m_pend = 16'h0;
    m_shad = 16'h0;
    check_model();
    for (int i = 1; i < RD; i++) begin
      tick();
      check("rst2_slot_an", 32'(an), (i >= DT) ? 32'hE : 32'hF);
    end

    // Randomized run against the model.
    for (int i = 0; i < 1200; i++) begin
      logic [15:0] masks[5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
      load  = ($urandom_range(0, 5) == 0);
      value = 16'($urandom) & masks[$urandom_range(0, 4)];
      if ($urandom_range(0, 40) == 0) lz_en = ~lz_en;
      tick();
    end
    load = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
